// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : cpu_pkg
// Purpose  : Word/address widths and memory responder state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 9;
  localparam int MEM_WAIT_W = 4;   // wait counter covers WAIT_STATES 0..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Interface: mem_responder_if
// Purpose  : Read/Write memory request bus between datapath and responder.
//            MemErr exists only when MEM_ADDR_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
  parameter int DATA_W = cpu_pkg::DATA_W
);

  logic              Read;
  logic              Write;
  logic [31:0]       MAR_q;
  logic [DATA_W-1:0] MDR_q;
  logic [DATA_W-1:0] Mdatain;
  logic              MemDone;
  logic              MemBusy;
`ifdef MEM_ADDR_CHECK_EN
  logic              MemErr;
`endif

  modport master (
    output Read, Write, MAR_q, MDR_q,
    input  Mdatain, MemDone, MemBusy
`ifdef MEM_ADDR_CHECK_EN
    , input MemErr
`endif
  );

  modport slave (
    input  Read, Write, MAR_q, MDR_q,
    output Mdatain, MemDone, MemBusy
`ifdef MEM_ADDR_CHECK_EN
    , output MemErr
`endif
  );

endinterface
`default_nettype wire

// File: rtl/mem_ram_sp.sv
`default_nettype none
// ============================================================================
// Module   : mem_ram_sp
// Purpose  : Single-port synchronous RAM, write enable, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_ram_sp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_in_range;

  // Indices past DEPTH (when DEPTH < 2**ADDR_W) have no storage behind them.
  assign w_in_range = (int'(i_addr) < DEPTH);

  always_ff @(posedge clk) begin
    if (i_we && w_in_range) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_re) begin
      o_rdata <= w_in_range ? r_mem[i_addr] : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Memory-side responder servicing datapath Read/Write via MAR/MDR.
//            Optional MEM_ADDR_CHECK_EN adds out-of-range detection on MemErr.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder #(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic           Clock,
  input  logic           Clear,
  mem_responder_if.slave bus
);
  import cpu_pkg::*;

  localparam logic [MEM_WAIT_W-1:0] c_wait_last =
      (WAIT_STATES > 0) ? MEM_WAIT_W'(WAIT_STATES - 1) : '0;

  mem_state_t            r_state, w_state_n;
  logic [MEM_WAIT_W-1:0] r_wait_cnt, w_wait_cnt_n;
  logic [ADDR_W-1:0]     r_addr, w_acc_addr;
  logic [DATA_W-1:0]     r_wdata, w_acc_wdata, w_ram_q;
  logic                  r_wr, w_acc_wr, w_acc_bad;
  logic                  w_req, w_capture, w_commit, w_live;
  logic                  w_ram_we, w_ram_re;
  logic                  r_done, r_busy;

  assign w_req     = bus.Read | bus.Write;
  assign w_capture = (r_state == IDLE) && w_req;
  assign w_commit  = (w_state_n == DONE);

  // With zero wait states the commit edge is the capture edge, so the
  // access must use the live bus rather than the capture registers.
  assign w_live      = (r_state == IDLE);
  assign w_acc_addr  = w_live ? bus.MAR_q[ADDR_W-1:0] : r_addr;
  assign w_acc_wdata = w_live ? bus.MDR_q : r_wdata;
  assign w_acc_wr    = w_live ? bus.Write : r_wr;

  assign w_ram_we = w_commit &  w_acc_wr & ~w_acc_bad;
  assign w_ram_re = w_commit & ~w_acc_wr & ~w_acc_bad;

  always_comb begin
    w_state_n    = r_state;
    w_wait_cnt_n = r_wait_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_wait_cnt_n = '0;
          if (WAIT_STATES == 0) w_state_n = DONE;
          else                  w_state_n = WAIT;
        end
      end
      WAIT: begin
        if (r_wait_cnt == c_wait_last) w_state_n = DONE;
        else                           w_wait_cnt_n = r_wait_cnt + 1'b1;
      end
      DONE:    w_state_n = HOLD;
      HOLD:    if (!w_req) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wr       <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_wait_cnt <= w_wait_cnt_n;
      r_done     <= w_commit;
      r_busy     <= (w_state_n != IDLE);
      if (w_capture) begin
        r_addr  <= bus.MAR_q[ADDR_W-1:0];
        r_wdata <= bus.MDR_q;
        r_wr    <= bus.Write;
      end
    end
  end

  mem_ram_sp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (Clock),
    .rst     (Clear),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_acc_addr),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_q)
  );

  assign bus.MemDone = r_done;
  assign bus.MemBusy = r_busy;

`ifdef MEM_ADDR_CHECK_EN
  logic r_bad, r_err, r_rd_zero, w_live_bad;

  assign w_live_bad = (bus.MAR_q >= 32'(DEPTH));
  assign w_acc_bad  = w_live ? w_live_bad : r_bad;

  // r_rd_zero masks the RAM output after a rejected read until the next read.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      r_bad     <= 1'b0;
      r_err     <= 1'b0;
      r_rd_zero <= 1'b0;
    end else begin
      if (w_capture) r_bad <= w_live_bad;
      if (w_commit)       r_err <= w_acc_bad;
      else if (w_capture) r_err <= 1'b0;
      if (w_commit && !w_acc_wr) r_rd_zero <= w_acc_bad;
    end
  end

  assign bus.Mdatain = r_rd_zero ? '0 : w_ram_q;
  assign bus.MemErr  = r_err;
`else
  assign w_acc_bad   = 1'b0;
  assign bus.Mdatain = w_ram_q;
`endif

endmodule
`default_nettype wire
